mult_div_unit: RTL and testbench

Multi-cycle multiply/divide unit in the EXE stage and the sole arithmetic writer of the HI/LO register pair. It accepts one operation per start pulse and computes the 64-bit result: signed/unsigned product, optionally accumulated or subtracted against the current HI/LO, or quotient/remainder. It then presents the result with a one-cycle finish pulse, which HI/LO samples directly. The pipeline holds EXE while busy is high.

---
 rtl/mult_div_unit_pkg.sv | 32 +++
 rtl/mult_div_unit_div_core.sv | 70 +++++++
 rtl/mult_div_unit.sv | 142 ++++++++++++++
 tb/tb_mult_div_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM encoding
// and small op-decode helpers.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MADD  = 3'd4,
    MDU_MADDU = 3'd5,
    MDU_MSUB  = 3'd6,
    MDU_MSUBU = 3'd7
  } mdu_op_t;

  typedef logic [2:0] mdu_state_t;

  localparam mdu_state_t ST_IDLE     = 3'd0;
  localparam mdu_state_t ST_MUL      = 3'd1;
  localparam mdu_state_t ST_DIV_ITER = 3'd2;
  localparam mdu_state_t ST_DIV_FIX  = 3'd3;
  localparam mdu_state_t ST_DONE     = 3'd4;

  function automatic logic op_is_div(input mdu_op_t op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(input mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD) || (op == MDU_MSUB);
  endfunction

endpackage

// File: rtl/mult_div_unit_div_core.sv
// Iterative 32-bit unsigned restoring divider, one quotient bit per cycle.
// done is high during the 32nd iteration cycle; results are stable the cycle after.
module mult_div_unit_div_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        active_q, active_d;

  logic [32:0] partial;
  logic [32:0] diff;
  logic        ge;

  always_comb begin
    // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder
    partial  = {rem_q, quo_q[31]};
    diff     = partial - {1'b0, dvs_q};
    ge       = partial >= {1'b0, dvs_q};
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load) begin
      rem_d    = '0;
      quo_d    = dividend;
      dvs_d    = divisor;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      rem_d = ge ? diff[31:0] : partial[31:0];
      quo_d = {quo_q[30:0], ge};
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign done      = active_q && (cnt_q == 5'd31);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit feeding HI/LO: signed/unsigned multiply with optional
// accumulate/subtract, and iterative divide with sign fixup.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  mdu_op_t     op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic        flush,
  output logic        busy,
  output logic        finish,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  mdu_state_t  state_q, state_d;
  mdu_op_t     op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] res_q, res_d;

  logic        accept;
  logic        in_signed_div;
  logic [31:0] abs_a, abs_b;
  logic        div_clr, div_done;
  logic [31:0] div_quo, div_rem;

  logic               mul_signed;
  logic signed [63:0] mul_a, mul_b, product;
  logic [63:0]        mul_res;
  logic               q_neg, r_neg;
  logic [63:0]        div_res;

  assign accept        = (state_q == ST_IDLE) && start && !flush;
  assign in_signed_div = (op == MDU_DIV);
  assign abs_a         = (in_signed_div && src_a[31]) ? (32'd0 - src_a) : src_a;
  assign abs_b         = (in_signed_div && src_b[31]) ? (32'd0 - src_b) : src_b;
  // A flush also parks the divider so a cancelled divide leaves no state behind
  assign div_clr       = rst || flush;

  mult_div_unit_div_core u_div_core (
    .clk       (clk),
    .rst       (div_clr),
    .load      (accept && op_is_div(op)),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    mul_signed = op_is_signed(op_q);
    mul_a      = {{32{mul_signed & a_q[31]}}, a_q};
    mul_b      = {{32{mul_signed & b_q[31]}}, b_q};
    product    = mul_a * mul_b;
    case (op_q)
      MDU_MADD, MDU_MADDU: mul_res = acc_q + product;
      MDU_MSUB, MDU_MSUBU: mul_res = acc_q - product;
      default:             mul_res = product;
    endcase
  end

  always_comb begin
    q_neg = (op_q == MDU_DIV) && (a_q[31] ^ b_q[31]);
    r_neg = (op_q == MDU_DIV) && a_q[31];
    if (b_q == 32'd0) begin
      div_res = {a_q, 32'hFFFF_FFFF};
    end else begin
      div_res = {r_neg ? (32'd0 - div_rem) : div_rem, q_neg ? (32'd0 - div_quo) : div_quo};
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_d    = op;
            a_d     = src_a;
            b_d     = src_b;
            acc_d   = {hi_in, lo_in};
            state_d = op_is_div(op) ? ST_DIV_ITER : ST_MUL;
          end
        end
        ST_MUL: begin
          res_d   = mul_res;
          state_d = ST_DONE;
        end
        ST_DIV_ITER: begin
          if (div_done) begin
            state_d = ST_DIV_FIX;
          end
        end
        ST_DIV_FIX: begin
          res_d   = div_res;
          state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= MDU_MULT;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign finish = (state_q == ST_DONE);
  assign hi_out = res_q[63:32];
  assign lo_out = res_q[31:0];

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver pushes reference results on acceptance,
// monitor pops and compares on every finish pulse.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  mdu_op_t     op;
  logic [31:0] src_a, src_b, hi_in, lo_in;
  logic        busy, finish;
  logic [31:0] hi_out, lo_out;

  mult_div_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .hi_in  (hi_in),
    .lo_in  (lo_in),
    .flush  (flush),
    .busy   (busy),
    .finish (finish),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          fin_cyc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  logic fin_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: plain arithmetic from the operation definitions
  function automatic logic [63:0] ref_model(input mdu_op_t o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] h,
                                            input logic [31:0] l);
    longint      sa, sb;
    logic [63:0] p, acc;
    int          qa, qb, q, r;
    acc = {h, l};
    if (o == MDU_MULT || o == MDU_MADD || o == MDU_MSUB) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      p  = 64'(sa * sb);
    end else begin
      p = {32'd0, a} * {32'd0, b};
    end
    case (o)
      MDU_MULT, MDU_MULTU: return p;
      MDU_MADD, MDU_MADDU: return acc + p;
      MDU_MSUB, MDU_MSUBU: return acc - p;
      MDU_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        qa = int'(a);
        qb = int'(b);
        q  = qa / qb;
        r  = qa % qb;
        return {32'(r), 32'(q)};
      end
    endcase
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (fin_prev) check("busy_after_finish", 64'(busy), 64'd0);
      if (finish) begin
        check("finish_single_pulse", 64'(fin_prev), 64'd0);
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_finish: actual=finish at cycle %0d required=no finish", cyc);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_cycle"}, 64'(cyc), 64'(e.fin_cyc));
          check({e.name, "_hi"}, 64'(hi_out), 64'(e.res[63:32]));
          check({e.name, "_lo"}, 64'(lo_out), 64'(e.res[31:0]));
        end
      end
    end
    fin_prev = finish && !rst;
  end

  // Called just after a negedge; holds start until accepted, returns accept cycle
  task automatic do_op(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] h, input logic [31:0] l, input string name,
                       input bit push, output int acc_cyc);
    int n = 0;
    op = o; src_a = a; src_b = b; hi_in = h; lo_in = l; start = 1'b1;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL %s_accept: actual=busy stuck required=accepted", name);
      start = 1'b0;
      acc_cyc = -1;
      return;
    end
    acc_cyc = cyc;
    if (push) sb_q.push_back('{ref_model(o, a, b, h, l), cyc + (op_is_div(o) ? 34 : 2), name});
    @(negedge clk);
    check({name, "_busy"}, 64'(busy), 64'd1);
    start = 1'b0;
    // Scramble inputs to prove the operands were latched
    src_a = $urandom; src_b = $urandom; hi_in = $urandom; lo_in = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: actual=%0d pending required=0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c1, c2;
    mdu_op_t ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = MDU_MULT;
    src_a = '0; src_b = '0; hi_in = '0; lo_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_finish", 64'(finish), 64'd0);
    check("reset_hi", 64'(hi_out), 64'd0);
    check("reset_lo", 64'(lo_out), 64'd0);

    do_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, "mult", 1'b1, c1);
    do_op(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, "multu", 1'b1, c2);
    check("b2b_mul_accept", 64'(c2), 64'(c1 + 3));
    do_op(MDU_MADD, 32'd2, 32'd3, 32'd0, 32'hFFFF_FFFF, "madd", 1'b1, c1);
    do_op(MDU_MSUBU, 32'd1, 32'd1, 32'd0, 32'd0, "msubu", 1'b1, c1);
    do_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, "div_neg7_2", 1'b1, c1);
    do_op(MDU_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, "divu_100_7", 1'b1, c2);
    check("b2b_div_accept", 64'(c2), 64'(c1 + 35));
    do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, "div_ovf", 1'b1, c1);
    do_op(MDU_DIVU, 32'd5, 32'd0, 32'd0, 32'd0, "divu_by0", 1'b1, c1);
    do_op(MDU_DIV, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'd0, "div_by0", 1'b1, c1);
    drain();

    // Flush in T+10 of a divide
    do_op(MDU_DIV, 32'd1000, 32'd3, 32'd0, 32'd0, "flushed_div", 1'b0, c1);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_low", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);

    // Flush and start together: not accepted
    op = MDU_DIVU; src_a = 32'd9; src_b = 32'd2; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    do_op(MDU_DIV, 32'd12345, 32'hFFFF_FFF9, 32'd0, 32'd0, "after_flush", 1'b1, c1);
    drain();

    // Reset mid-divide
    do_op(MDU_DIVU, 32'd77, 32'd5, 32'd0, 32'd0, "reset_div", 1'b0, c1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_finish", 64'(finish), 64'd0);
    check("midrst_hi", 64'(hi_out), 64'd0);
    check("midrst_lo", 64'(lo_out), 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      ro = mdu_op_t'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = $urandom_range(0, 100);
        default: ;
      endcase
      do_op(ro, ra, rb, $urandom, $urandom, $sformatf("rand%0d_op%0d", i, ro), 1'b1, c1);
    end
    drain();

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
